contador_nivel2: RTL and testbench

CONTADOR_NIVEL2 -- requirements
Module: contador_nivel2

---
 rtl/contador_nivel2.sv | 102 ++++++++++
 tb/tb_contador_nivel2.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/contador_nivel2.sv
`default_nettype none
// ============================================================================
// Module   : contador_nivel2 (+ contador_nivel2_digit)
// Brief    : M:SS down-counter (9:59..0:00) built from chained per-digit stages
// Revision : 1.0 - initial release
// ============================================================================

module contador_nivel2_digit #(
    parameter int MODULUS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] preset,
    output logic [3:0] count,
    output logic       is_zero
);

    localparam logic [3:0] c_MAX_DIGIT = 4'(MODULUS - 1);

    logic [3:0] r_count;
    logic [3:0] w_preset;

    // Out-of-range presets saturate to the digit's largest legal value
    assign w_preset = (preset > c_MAX_DIGIT) ? c_MAX_DIGIT : preset;
    assign is_zero  = (r_count == 4'd0);
    assign count    = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (load) begin
            r_count <= w_preset;
        end else if (dec) begin
            r_count <= is_zero ? c_MAX_DIGIT : (r_count - 4'd1);
        end
    end

endmodule

module contador_nivel2 (
    input  logic [3:0] uni_sec,
    input  logic [3:0] dez_sec,
    input  logic [3:0] min,
    input  logic       clk,
    input  logic       enable,
    input  logic       load,
    output logic [3:0] count_us,
    output logic [3:0] count_ds,
    output logic [3:0] count_m,
    output logic       zero,
    input  logic       rst_n
);

    logic w_us_zero;
    logic w_ds_zero;
    logic w_m_zero;
    logic w_dec_us;
    logic w_dec_ds;
    logic w_dec_m;

    assign zero = w_us_zero & w_ds_zero & w_m_zero;

    // Gating on zero stops the chain at 0:00 instead of wrapping to 9:59
    assign w_dec_us = enable & ~zero;
    assign w_dec_ds = w_dec_us & w_us_zero;
    assign w_dec_m  = w_dec_ds & w_ds_zero;

    contador_nivel2_digit #(.MODULUS(10)) u_units (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .dec     (w_dec_us),
        .preset  (uni_sec),
        .count   (count_us),
        .is_zero (w_us_zero)
    );

    contador_nivel2_digit #(.MODULUS(6)) u_tens (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .dec     (w_dec_ds),
        .preset  (dez_sec),
        .count   (count_ds),
        .is_zero (w_ds_zero)
    );

    contador_nivel2_digit #(.MODULUS(10)) u_minutes (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .dec     (w_dec_m),
        .preset  (min),
        .count   (count_m),
        .is_zero (w_m_zero)
    );

endmodule

`default_nettype wire

// File: tb/tb_contador_nivel2.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_nivel2
// Brief    : Directed self-checking bench for the M:SS down-counter
// Revision : 1.0 - initial release
// ============================================================================

module tb_contador_nivel2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] uni_sec;
    logic [3:0] dez_sec;
    logic [3:0] min;
    logic       enable;
    logic       load;
    logic [3:0] count_us;
    logic [3:0] count_ds;
    logic [3:0] count_m;
    logic       zero;

    int errors = 0;
    int checks = 0;

    contador_nivel2 dut (
        .uni_sec  (uni_sec),
        .dez_sec  (dez_sec),
        .min      (min),
        .clk      (clk),
        .enable   (enable),
        .load     (load),
        .count_us (count_us),
        .count_ds (count_ds),
        .count_m  (count_m),
        .zero     (zero),
        .rst_n    (rst_n)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; uni_sec = 4'd3; dez_sec = 4'd4; min = 4'd5;
        load = 1'b1; enable = 1'b1;
        tick(); tick();
        checks++;
        if ({count_m, count_ds, count_us, zero} !== {4'd0, 4'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset: got %0d:%0d%0d zero=%b, expected 0:00 zero=1",
                     count_m, count_ds, count_us, zero);
        end
        load = 1'b0; enable = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({count_m, count_ds, count_us, zero} !== {4'd0, 4'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release: got %0d:%0d%0d zero=%b, expected 0:00 zero=1",
                     count_m, count_ds, count_us, zero);
        end
    endtask

    task automatic test_load_run();
        int total;
        uni_sec = 4'd7; dez_sec = 4'd5; min = 4'd8; load = 1'b1; enable = 1'b0;
        tick();
        checks++;
        if ({count_m, count_ds, count_us, zero} !== {4'd8, 4'd5, 4'd7, 1'b0}) begin
            errors++;
            $display("FAIL load_857: got %0d:%0d%0d zero=%b, expected 8:57 zero=0",
                     count_m, count_ds, count_us, zero);
        end
        load = 1'b0; enable = 1'b1;
        total = 8 * 60 + 57;
        // 20 steps covers 8:50 -> 8:49 and 8:40 -> 8:39 digit wraps
        for (int i = 0; i < 20; i++) begin
            tick();
            total--;
            checks++;
            if ({count_m, count_ds, count_us, zero} !==
                {4'(total / 60), 4'((total % 60) / 10), 4'(total % 10), 1'b0}) begin
                errors++;
                $display("FAIL run_step%0d: got %0d:%0d%0d zero=%b, expected %0d:%0d%0d zero=0",
                         i, count_m, count_ds, count_us, zero,
                         total / 60, (total % 60) / 10, total % 10);
            end
        end
    endtask

    task automatic test_borrow_chain();
        int secs;
        uni_sec = 4'd0; dez_sec = 4'd0; min = 4'd1; load = 1'b1; enable = 1'b0;
        tick();
        checks++;
        if ({count_m, count_ds, count_us, zero} !== {4'd1, 4'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL load_100: got %0d:%0d%0d zero=%b, expected 1:00 zero=0",
                     count_m, count_ds, count_us, zero);
        end
        load = 1'b0; enable = 1'b1;
        tick();
        checks++;
        if ({count_m, count_ds, count_us, zero} !== {4'd0, 4'd5, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL borrow_059: got %0d:%0d%0d zero=%b, expected 0:59 zero=0",
                     count_m, count_ds, count_us, zero);
        end
        secs = 59;
        for (int i = 0; i < 59; i++) begin
            tick();
            secs--;
            checks++;
            if ({count_m, count_ds, count_us, zero} !==
                {4'd0, 4'(secs / 10), 4'(secs % 10), (secs == 0)}) begin
                errors++;
                $display("FAIL down_to_zero%0d: got %0d:%0d%0d zero=%b, expected 0:%0d%0d zero=%b",
                         i, count_m, count_ds, count_us, zero, secs / 10, secs % 10, secs == 0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({count_m, count_ds, count_us, zero} !== {4'd0, 4'd0, 4'd0, 1'b1}) begin
                errors++;
                $display("FAIL zero_hold%0d: got %0d:%0d%0d zero=%b, expected 0:00 zero=1",
                         i, count_m, count_ds, count_us, zero);
            end
        end
    endtask

    task automatic test_clamp();
        uni_sec = 4'd15; dez_sec = 4'd7; min = 4'd12; load = 1'b1; enable = 1'b0;
        tick();
        checks++;
        if ({count_m, count_ds, count_us, zero} !== {4'd9, 4'd5, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL clamp: got %0d:%0d%0d zero=%b, expected 9:59 zero=0",
                     count_m, count_ds, count_us, zero);
        end
        uni_sec = 4'd10; dez_sec = 4'd6; min = 4'd9;
        tick();
        checks++;
        if ({count_m, count_ds, count_us, zero} !== {4'd9, 4'd5, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL clamp_edge: got %0d:%0d%0d zero=%b, expected 9:59 zero=0",
                     count_m, count_ds, count_us, zero);
        end
        load = 1'b0;
    endtask

    task automatic test_priority_hold();
        uni_sec = 4'd4; dez_sec = 4'd3; min = 4'd2; load = 1'b1; enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({count_m, count_ds, count_us, zero} !== {4'd2, 4'd3, 4'd4, 1'b0}) begin
                errors++;
                $display("FAIL load_over_enable%0d: got %0d:%0d%0d zero=%b, expected 2:34 zero=0",
                         i, count_m, count_ds, count_us, zero);
            end
        end
        load = 1'b0; enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({count_m, count_ds, count_us, zero} !== {4'd2, 4'd3, 4'd4, 1'b0}) begin
                errors++;
                $display("FAIL hold%0d: got %0d:%0d%0d zero=%b, expected 2:34 zero=0",
                         i, count_m, count_ds, count_us, zero);
            end
        end
        enable = 1'b1;
        tick();
        checks++;
        if ({count_m, count_ds, count_us, zero} !== {4'd2, 4'd3, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL resume: got %0d:%0d%0d zero=%b, expected 2:33 zero=0",
                     count_m, count_ds, count_us, zero);
        end
    endtask

    task automatic test_async_reset();
        uni_sec = 4'd0; dez_sec = 4'd2; min = 4'd3; load = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick();
        checks++;
        if ({count_m, count_ds, count_us, zero} !== {4'd3, 4'd1, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL count_318: got %0d:%0d%0d zero=%b, expected 3:18 zero=0",
                     count_m, count_ds, count_us, zero);
        end
        // Reset pulse sits entirely between two rising edges
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({count_m, count_ds, count_us, zero} !== {4'd0, 4'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got %0d:%0d%0d zero=%b, expected 0:00 zero=1",
                     count_m, count_ds, count_us, zero);
        end
        #1;
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if ({count_m, count_ds, count_us, zero} !== {4'd0, 4'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL no_resume: got %0d:%0d%0d zero=%b, expected 0:00 zero=1",
                     count_m, count_ds, count_us, zero);
        end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_borrow_chain();
        test_clamp();
        test_priority_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
